// File: rtl/div_mult_unit.sv
// div_mult_unit: iterative HI/LO multiply/divide unit.
// MTHI/MTLO write HI/LO directly in one cycle. MULT/MULTU/DIV/DIVU run
// bit-serially over WIDTH cycles on operand magnitudes. A final FIX cycle
// applies the sign, writes HI/LO, drops busy and pulses done.
module div_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MTHI  = 3'b000;
  localparam logic [2:0] OP_MTLO  = 3'b001;
  localparam logic [2:0] OP_MULT  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Iteration counter, 0..WIDTH-1 during RUN.
  logic [CW-1:0] cnt_q, cnt_d;

  // Shared 2*WIDTH working register.
  //   multiply: upper half = running partial product, lower half = multiplier
  //             bits still to consume (shifted out from bit 0).
  //   divide:   upper half = partial remainder, lower half = dividend bits
  //             still to consume (from the top) with quotient bits entering
  //             at bit 0.
  logic [2*WIDTH-1:0] acc_q, acc_d;

  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0] opb_q, opb_d;

  logic is_div_q, is_div_d;   // 1 = divide, 0 = multiply
  logic sq_q, sq_d;           // sign of product / quotient
  logic sr_q, sr_d;           // sign of remainder (dividend sign)
  logic dz_q, dz_d;           // divisor was zero

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Operand decode at the accepting edge.
  logic             signed_op;
  logic             is_muldiv;
  logic             s1, s2;
  logic [WIDTH-1:0] mag1, mag2;

  // One shift-add multiply step.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  // One restoring divide step.
  logic [WIDTH:0]     div_r;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [WIDTH-1:0]   rem_new;
  logic [2*WIDTH-1:0] div_next;

  // Final results before sign correction.
  logic [WIDTH-1:0] quo_mag, rem_mag;

  // Operand magnitudes and sign flags for the incoming request.
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV);
    is_muldiv = (op[2:1] == 2'b01) || (op[2:1] == 2'b10);
    s1        = signed_op & in_1[WIDTH-1];
    s2        = signed_op & in_2[WIDTH-1];
    mag1      = s1 ? -in_1 : in_1;
    mag2      = s2 ? -in_2 : in_2;
  end

  // Datapath for a single multiply or divide iteration.
  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole accumulator right by one (carry enters at the top).
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opb_q : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: bring down the next dividend bit; subtract when it fits.
    // When div_ge holds, the true difference is below the divisor, so the
    // low WIDTH bits of the subtraction are exact.
    div_r    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge   = (div_r >= {1'b0, opb_q});
    div_diff = div_r[WIDTH-1:0] - opb_q;
    rem_new  = div_ge ? div_diff : div_r[WIDTH-1:0];
    div_next = {rem_new, acc_q[WIDTH-2:0], div_ge};

    quo_mag  = acc_q[WIDTH-1:0];
    rem_mag  = acc_q[2*WIDTH-1:WIDTH];
  end

  // Next-state and register-update logic for the IDLE/RUN/FIX sequence.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    sq_d     = sq_q;
    sr_d     = sr_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (op == OP_MTHI) begin
            hi_d = in_1;
          end else if (op == OP_MTLO) begin
            lo_d = in_1;
          end else if (is_muldiv) begin
            is_div_d = op[2];
            sq_d     = s1 ^ s2;
            sr_d     = s1;
            dz_d     = (in_2 == {WIDTH{1'b0}});
            opb_d    = op[2] ? mag2 : mag1;
            acc_d    = {{WIDTH{1'b0}}, (op[2] ? mag1 : mag2)};
            cnt_d    = '0;
            busy_d   = 1'b1;
            state_d  = RUN;
          end
        end
      end

      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        if (is_div_q) begin
          // With a zero divisor the restoring loop already yields an
          // all-ones quotient and a remainder equal to |dividend|; the
          // remainder's sign correction then reproduces the raw dividend.
          lo_d = dz_q ? {WIDTH{1'b1}} : (sq_q ? -quo_mag : quo_mag);
          hi_d = sr_q ? -rem_mag : rem_mag;
        end else begin
          {hi_d, lo_d} = sq_q ? -acc_q : acc_q;
        end
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      sq_q     <= sq_d;
      sr_q     <= sr_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_div_mult_unit.sv
// Testbench for div_mult_unit: a 32-bit and an 8-bit instance share one
// stimulus stream; an arithmetic reference model predicts HI/LO/busy/done
// for each and a compare process checks both every cycle.
module tb_div_mult_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] in_1;
  logic [31:0] in_2;

  logic        busy32, done32;
  logic [31:0] hi32, lo32;
  logic        busy8, done8;
  logic [7:0]  hi8, lo8;

  div_mult_unit #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .in_1(in_1), .in_2(in_2),
    .busy(busy32), .done(done32), .hi(hi32), .lo(lo32)
  );

  div_mult_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .in_1(in_1[7:0]), .in_2(in_2[7:0]),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference result {hi, lo} for a w-bit operation, from plain arithmetic.
  function automatic logic [127:0] ref_calc(input int w, input logic [2:0] o,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0] mask, p, uh, ul;
    longint sa, sb, q, r;
    mask = (64'd1 << w) - 64'd1;
    sa = $signed(a << (64 - w)) >>> (64 - w);
    sb = $signed(b << (64 - w)) >>> (64 - w);
    uh = '0;
    ul = '0;
    case (o)
      3'd2: begin p = sa * sb; ul = p & mask; uh = (p >> w) & mask; end
      3'd3: begin p = a * b;   ul = p & mask; uh = (p >> w) & mask; end
      3'd4: begin
        if (b == 64'd0) begin
          ul = mask; uh = a;
        end else begin
          // Min / -1 gives +2^(w-1) here, which wraps back to min when masked.
          q = sa / sb; r = sa % sb;
          ul = 64'(q) & mask; uh = 64'(r) & mask;
        end
      end
      3'd5: begin
        if (b == 64'd0) begin
          ul = mask; uh = a;
        end else begin
          ul = a / b; uh = a % b;
        end
      end
      default: ;
    endcase
    return {uh, ul};
  endfunction

  // Behavioural model: index 0 is the 32-bit unit, index 1 the 8-bit unit.
  logic [63:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];
  bit          m_busy[2], m_done[2];
  int          m_left[2];

  always @(posedge clk) begin : model_p
    int w;
    logic [63:0] mask, a, b;
    logic [127:0] res;
    for (int k = 0; k < 2; k++) begin
      w    = (k == 0) ? 32 : 8;
      mask = (64'd1 << w) - 64'd1;
      a    = {32'b0, in_1} & mask;
      b    = {32'b0, in_2} & mask;
      if (!reset) begin
        m_hi[k] <= '0; m_lo[k] <= '0; m_busy[k] <= 1'b0; m_done[k] <= 1'b0; m_left[k] <= 0;
      end else begin
        m_done[k] <= 1'b0;
        if (m_busy[k]) begin
          if (m_left[k] == 1) begin
            m_hi[k] <= p_hi[k]; m_lo[k] <= p_lo[k];
            m_busy[k] <= 1'b0; m_done[k] <= 1'b1;
          end
          m_left[k] <= m_left[k] - 1;
        end else if (start) begin
          case (op)
            3'd0: m_hi[k] <= a;
            3'd1: m_lo[k] <= a;
            3'd2, 3'd3, 3'd4, 3'd5: begin
              res = ref_calc(w, op, a, b);
              p_hi[k] <= res[127:64];
              p_lo[k] <= res[63:0];
              m_busy[k] <= 1'b1;
              m_left[k] <= w + 1;
            end
            default: ;
          endcase
          if (k == 0 && op <= 3'd5)
            $display("[TB] w32 accept op=%0d in_1=%h in_2=%h", op, in_1, in_2);
        end
      end
    end
  end

  // Every-cycle comparison of both units against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy32", 128'(busy32), 128'(m_busy[0]));
      chk("done32", 128'(done32), 128'(m_done[0]));
      chk("hi32",   128'(hi32),   128'(m_hi[0]));
      chk("lo32",   128'(lo32),   128'(m_lo[0]));
      chk("busy8",  128'(busy8),  128'(m_busy[1]));
      chk("done8",  128'(done8),  128'(m_done[1]));
      chk("hi8",    128'(hi8),    128'(m_hi[1]));
      chk("lo8",    128'(lo8),    128'(m_lo[1]));
    end
  end

  // Pulse start for one cycle, then scramble the operands mid-run.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; in_1 = a; in_2 = b;
    @(negedge clk);
    start = 1'b0; in_1 = $urandom; in_2 = $urandom;
  endtask

  task automatic wait_done32(output int cyc);
    cyc = 0;
    while (done32 !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
  endtask

  function automatic logic [31:0] rv();
    case ($urandom % 7)
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'hFFFFFF80;
      4: return 32'h1;
      5: return $urandom % 16;
      default: return $urandom;
    endcase
  endfunction

  typedef struct {
    logic [2:0]  o;
    logic [31:0] a, b, ehi, elo;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    vecs[0] = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1] = '{3'd2, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[2] = '{3'd4, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[3] = '{3'd4, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[4] = '{3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003};
    vecs[5] = '{3'd5, 32'd100,      32'd7,        32'd2,        32'd14};
    vecs[6] = '{3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[7] = '{3'd5, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[8] = '{3'd4, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};

    // Pin the reference model with hand-computed values.
    chk("ref_div_7_m2",   ref_calc(32, 3'd4, 64'd7, 64'hFFFFFFFE), {64'h1, 64'hFFFFFFFD});
    chk("ref_mult_m3_7",  ref_calc(32, 3'd2, 64'hFFFFFFFD, 64'd7), {64'hFFFFFFFF, 64'hFFFFFFEB});
    chk("ref_divu_5_0",   ref_calc(32, 3'd5, 64'd5, 64'd0), {64'h5, 64'hFFFFFFFF});
    chk("ref_div8_ovf",   ref_calc(8, 3'd4, 64'h80, 64'hFF), {64'h0, 64'h80});
    chk("ref_multu8_ff",  ref_calc(8, 3'd3, 64'hFF, 64'hFF), {64'hFE, 64'h01});

    reset = 1'b0; start = 1'b0; op = 3'd0; in_1 = '0; in_2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 128'(hi32), 128'(0));
    chk("rst_lo", 128'(lo32), 128'(0));
    chk("rst_busy", 128'(busy32), 128'(0));
    reset  = 1'b1;
    chk_en = 1'b1;

    // MTHI / MTLO: visible next cycle, no done.
    issue(3'd0, 32'hDEADBEEF, 32'h0);
    chk("mthi_hi", 128'(hi32), 128'(32'hDEADBEEF));
    chk("mthi_done", 128'(done32), 128'(0));
    issue(3'd1, 32'h12345678, 32'h0);
    chk("mtlo_lo", 128'(lo32), 128'(32'h12345678));
    chk("mtlo_hi", 128'(hi32), 128'(32'hDEADBEEF));
    chk("mtlo_busy", 128'(busy32), 128'(0));

    // Directed mul/div, each started in the done cycle of the previous one.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].o, vecs[i].a, vecs[i].b);
      wait_done32(lat);
      chk("dir_latency", 128'(lat), 128'(33));
      chk("dir_hi", 128'(hi32), 128'(vecs[i].ehi));
      chk("dir_lo", 128'(lo32), 128'(vecs[i].elo));
      if (i == 0) begin
        chk("w8_multu_hi", 128'(hi8), 128'(8'hFE));
        chk("w8_multu_lo", 128'(lo8), 128'(8'h01));
      end
    end

    // Starts while busy are ignored.
    issue(3'd5, 32'd1000, 32'd9);
    @(negedge clk);
    chk("hs_busy", 128'(busy32), 128'(1));
    issue(3'd0, 32'h55555555, 32'h0);
    repeat (2) @(negedge clk);
    issue(3'd5, 32'd77, 32'd3);
    chk("hs_hold_hi", 128'(hi32), 128'(32'hFFFFFFF9));
    wait_done32(lat);
    chk("hs_hi", 128'(hi32), 128'(32'd1));
    chk("hs_lo", 128'(lo32), 128'(32'd111));

    // Reset in the middle of a run.
    issue(3'd2, 32'd12345, 32'd678);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("mid_rst_busy", 128'(busy32), 128'(0));
    chk("mid_rst_done", 128'(done32), 128'(0));
    chk("mid_rst_hi", 128'(hi32), 128'(0));
    chk("mid_rst_lo", 128'(lo32), 128'(0));
    repeat (40) @(negedge clk);
    chk("mid_rst_nodone", 128'(busy32), 128'(0));

    // 8-bit latency.
    issue(3'd3, 32'hFF, 32'hFF);
    wait_done8(lat);
    chk("w8_latency", 128'(lat), 128'(9));
    chk("w8_hi", 128'(hi8), 128'(8'hFE));
    chk("w8_lo", 128'(lo8), 128'(8'h01));
    wait_done32(lat);
    chk("w32_ffxff_lo", 128'(lo32), 128'(32'h0000FE01));

    // Random traffic, including starts while busy and reserved ops.
    repeat (3000) begin
      @(negedge clk);
      start = ($urandom % 4 == 0);
      op    = 3'($urandom % 8);
      in_1  = rv();
      in_2  = rv();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
